led_array_ctrl: RTL and testbench

//  Parametrised LED/button front-panel controller for board bring-up tops.

---
 rtl/led_array_ctrl.sv | 160 ++++++++++++++++
 tb/tb_led_array_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_array_ctrl.sv
// rtl/led_array_ctrl.sv - front-panel LED driver with PWM, blink, button debounce
// Optional breathe mode: define LED_ARRAY_CTRL_BREATHE_EN.
module led_array_ctrl #(
    parameter int NUM_LEDS        = 4,
    parameter int NUM_BUTTONS     = 2,
    parameter int PWM_BITS        = 8,
    parameter int BLINK_TICKS     = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int BREATHE_STEP    = 100_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_BUTTONS-1:0]      button_n,
    input  logic                        cfg_we,
    input  logic [$clog2(NUM_LEDS):0]   cfg_sel,
    input  logic [2:0]                  cfg_mode,
    input  logic [PWM_BITS-1:0]         cfg_level,
    output logic [NUM_LEDS-1:0]         led,
    output logic [NUM_BUTTONS-1:0]      btn_state,
    output logic [NUM_BUTTONS-1:0]      btn_press
);

    localparam int SEL_W = $clog2(NUM_LEDS) + 1;
    localparam int BLK_W = $clog2(BLINK_TICKS);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [2:0] MODE_OFF     = 3'd0;
    localparam logic [2:0] MODE_ON      = 3'd1;
    localparam logic [2:0] MODE_BLINK   = 3'd2;
    localparam logic [2:0] MODE_FOLLOW  = 3'd3;
    localparam logic [2:0] MODE_BREATHE = 3'd4;

    if (NUM_LEDS < 1 || NUM_LEDS > 16 || NUM_BUTTONS < 1 || NUM_BUTTONS > 8 ||
        PWM_BITS < 1 || BLINK_TICKS < 2 || DEBOUNCE_CYCLES < 1 || BREATHE_STEP < 1) begin : g_bad_params
        $error("led_array_ctrl: parameter out of range");
    end

    logic [2:0]             mode_q  [NUM_LEDS];
    logic [PWM_BITS-1:0]    level_q [NUM_LEDS];
    logic [PWM_BITS-1:0]    pwm_cnt;
    logic [BLK_W-1:0]       blink_cnt;
    logic                   blink_phase;
    logic [NUM_BUTTONS-1:0] sync1;
    logic [NUM_BUTTONS-1:0] sync2;
    logic [DB_W-1:0]        db_cnt  [NUM_BUTTONS];
    logic [NUM_LEDS-1:0]    duty_on;
    logic [NUM_LEDS-1:0]    led_next;

    // Out-of-range cfg_sel matches no channel, so such writes fall through untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode_q[i]  <= MODE_OFF;
                level_q[i] <= '1;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (cfg_sel == SEL_W'(i)) begin
                    mode_q[i]  <= cfg_mode;
                    level_q[i] <= cfg_level;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLK_W'(1);
            end
        end
    end

`ifdef LED_ARRAY_CTRL_BREATHE_EN
    localparam int BRS_W = $clog2(BREATHE_STEP + 1);

    logic [BRS_W-1:0]    brs_cnt;
    logic [PWM_BITS:0]   br_pos;
    logic [PWM_BITS-1:0] breathe_lvl;

    // br_pos sweeps 2^(PWM_BITS+1) steps; the upper half mirrors the lower,
    // which holds both the top and bottom level for two consecutive steps.
    always_ff @(posedge clk) begin
        if (reset) begin
            brs_cnt <= '0;
            br_pos  <= '0;
        end else if (brs_cnt == BRS_W'(BREATHE_STEP - 1)) begin
            brs_cnt <= '0;
            br_pos  <= br_pos + (PWM_BITS+1)'(1);
        end else begin
            brs_cnt <= brs_cnt + BRS_W'(1);
        end
    end

    assign breathe_lvl = br_pos[PWM_BITS] ? ~br_pos[PWM_BITS-1:0] : br_pos[PWM_BITS-1:0];
`endif

    always_comb begin
        duty_on  = '0;
        led_next = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            duty_on[i] = level_q[i] > pwm_cnt;
            case (mode_q[i])
                MODE_ON:      led_next[i] = duty_on[i];
                MODE_BLINK:   led_next[i] = blink_phase & duty_on[i];
                MODE_FOLLOW:  led_next[i] = (|btn_state) & duty_on[i];
`ifdef LED_ARRAY_CTRL_BREATHE_EN
                MODE_BREATHE: led_next[i] = breathe_lvl > pwm_cnt;
`endif
                default:      led_next[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led <= '0;
        end else begin
            led <= led_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            btn_state <= '0;
            btn_press <= '0;
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                db_cnt[b] <= '0;
            end
        end else begin
            sync1     <= ~button_n;
            sync2     <= sync1;
            btn_press <= '0;
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                if (sync2[b] != btn_state[b]) begin
                    if (db_cnt[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        btn_state[b] <= ~btn_state[b];
                        btn_press[b] <= ~btn_state[b];
                        db_cnt[b]    <= '0;
                    end else begin
                        db_cnt[b] <= db_cnt[b] + DB_W'(1);
                    end
                end else begin
                    db_cnt[b] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_array_ctrl.sv
// tb/tb_led_array_ctrl.sv - randomized self-checking bench for led_array_ctrl
module tb_led_array_ctrl;

    localparam int NL   = 4;
    localparam int NB   = 2;
    localparam int PB   = 4;
    localparam int BT   = 10;
    localparam int DC   = 4;
    localparam int BS   = 2;
    localparam int HMAX = 16384;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] button_n;
    logic          cfg_we;
    logic [2:0]    cfg_sel;
    logic [2:0]    cfg_mode;
    logic [PB-1:0] cfg_level;
    logic [NL-1:0] led;
    logic [NB-1:0] btn_state;
    logic [NB-1:0] btn_press;

    always #5 clk = ~clk;

    led_array_ctrl #(
        .NUM_LEDS(NL), .NUM_BUTTONS(NB), .PWM_BITS(PB),
        .BLINK_TICKS(BT), .DEBOUNCE_CYCLES(DC), .BREATHE_STEP(BS)
    ) dut (
        .clk(clk), .reset(reset), .button_n(button_n),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .cfg_level(cfg_level),
        .led(led), .btn_state(btn_state), .btn_press(btn_press)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time-indexed view of the panel, t = clean edges since reset.
    bit            model_valid = 0;
    int            t;
    logic [2:0]    m_mode  [NL];
    logic [PB-1:0] m_level [NL];
    logic [NB-1:0] m_state;
    logic [NB-1:0] m_press;
    logic [NL-1:0] m_led;
    logic [NB-1:0] hist [HMAX];
    int            last_flip [NB];
    int            pwm, phase, e, lvl;
    bit            duty;
    logic [NB-1:0] flip;

    function automatic bit raw_at(input int idx, input int b);
        if (idx < 1 || idx >= HMAX) return 1'b0;
        return hist[idx][b];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            t = 0;
            for (int i = 0; i < NL; i++) begin
                m_mode[i]  = 3'd0;
                m_level[i] = '1;
            end
            for (int b = 0; b < NB; b++) last_flip[b] = 0;
            hist[0]     = '0;
            m_state     = '0;
            m_press     = '0;
            m_led       = '0;
            model_valid = 1;
        end else if (model_valid) begin
            pwm   = t % (1 << PB);
            phase = (t / BT) % 2;
            lvl   = (t / BS) % (2 << PB);
            lvl   = (lvl < (1 << PB)) ? lvl : ((2 << PB) - 1 - lvl);
            for (int i = 0; i < NL; i++) begin
                duty = int'(m_level[i]) > pwm;
                case (m_mode[i])
                    3'd1:    m_led[i] = duty;
                    3'd2:    m_led[i] = duty && (phase == 1);
                    3'd3:    m_led[i] = duty && (m_state != '0);
`ifdef LED_ARRAY_CTRL_BREATHE_EN
                    3'd4:    m_led[i] = lvl > pwm;
`endif
                    default: m_led[i] = 1'b0;
                endcase
            end
            // A button flips once its synchronised input (2 edges late) has
            // disagreed with the accepted level for DC edges since the last flip.
            e = t + 1;
            for (int b = 0; b < NB; b++) begin
                flip[b] = (e - last_flip[b]) >= DC;
                for (int k = 0; k < DC; k++) begin
                    if (raw_at(e - 2 - k, b) == m_state[b]) flip[b] = 1'b0;
                end
                if (flip[b]) last_flip[b] = e;
            end
            m_press = flip & ~m_state;
            m_state = m_state ^ flip;
            if (cfg_we && int'(cfg_sel) < NL) begin
                m_mode[cfg_sel[1:0]]  = cfg_mode;
                m_level[cfg_sel[1:0]] = cfg_level;
            end
            if (e < HMAX) hist[e] = ~button_n;
            t++;
        end
        #2;
        if (model_valid) begin
            check("led", 32'(led), 32'(m_led));
            check("btn_state", 32'(btn_state), 32'(m_state));
            check("btn_press", 32'(btn_press), 32'(m_press));
        end
    end

    int press_seen;
    int lat;
    int n;
    int hold [NB];

    task automatic cfg_write(input int sel, input int mode, input int level);
        cfg_we    = 1'b1;
        cfg_sel   = 3'(sel);
        cfg_mode  = 3'(mode);
        cfg_level = PB'(level);
        @(negedge clk);
        cfg_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic count_led(input int idx, output int cnt);
        cnt = 0;
        repeat (16) begin
            if (led[idx]) cnt++;
            @(negedge clk);
        end
    endtask

    task automatic run_cycles(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            if (btn_press[0]) press_seen++;
        end
    endtask

    initial begin
        reset     = 1'b1;
        button_n  = '1;
        cfg_we    = 1'b0;
        cfg_sel   = '0;
        cfg_mode  = '0;
        cfg_level = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            check("idle_led", 32'(led), 32'd0);
            check("idle_state", 32'(btn_state | btn_press), 32'd0);
            @(negedge clk);
        end

        cfg_write(1, 1, 4);
        count_led(1, n);
        check("on_level4_count", n, 4);
        cfg_write(1, 1, 0);
        count_led(1, n);
        check("on_level0_count", n, 0);
        cfg_write(1, 1, 15);
        count_led(1, n);
        check("on_level15_count", n, 15);

        cfg_write(2, 2, 15);
        run_cycles(45);
        cfg_write(5, 0, 0);
        count_led(1, n);
        check("sel5_ignored", n, 15);

        cfg_write(3, 3, 15);
        press_seen = 0;
        for (int g = 0; g < 4; g++) begin
            button_n[0] = 1'b0;
            run_cycles(2);
            button_n[0] = 1'b1;
            run_cycles(3);
        end
        run_cycles(8);
        check("glitch_press", press_seen, 0);

        button_n[0] = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            run_cycles(1);
            if (btn_state[0] && lat == 0) lat = c;
        end
        check("press_latency", lat, 6);
        check("press_pulses", press_seen, 1);
        count_led(3, n);
        check("follow_lit", n, 15);

        button_n[0] = 1'b1;
        press_seen = 0;
        run_cycles(20);
        check("release_pulses", press_seen, 0);
        check("release_state", 32'(btn_state), 32'd0);
        count_led(3, n);
        check("follow_dark", n, 0);

        button_n[1] = 1'b0;
        run_cycles(3);
        reset = 1'b1;
        @(negedge clk);
        check("rst_led", 32'(led), 32'd0);
        check("rst_state", 32'(btn_state), 32'd0);
        check("rst_press", 32'(btn_press), 32'd0);
        reset = 1'b0;
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (btn_state[1] && lat == 0) lat = c;
        end
        check("post_rst_latency", lat, 6);
        button_n[1] = 1'b1;
        run_cycles(12);

        cfg_write(0, 4, 15);
`ifndef LED_ARRAY_CTRL_BREATHE_EN
        count_led(0, n);
        check("mode4_off", n, 0);
`endif
        run_cycles(70);

        for (int b = 0; b < NB; b++) hold[b] = 1;
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 599) == 0);
            cfg_we    = ($urandom_range(0, 5) == 0);
            cfg_sel   = 3'($urandom_range(0, 7));
            cfg_mode  = 3'($urandom_range(0, 7));
            cfg_level = PB'($urandom);
            for (int b = 0; b < NB; b++) begin
                hold[b]--;
                if (hold[b] <= 0) begin
                    button_n[b] = ~button_n[b];
                    hold[b] = $urandom_range(1, 9);
                end
            end
            @(negedge clk);
        end
        reset  = 1'b0;
        cfg_we = 1'b0;
        run_cycles(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
